// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered EX stage with forwarding muxes, ALU, branch-target
// adder, valid/ready handshakes on both sides and an optional iterative
// multiply/divide unit (enabled by defining EX_MULDIV_EN). Without the macro,
// md_en ops complete in one cycle with result 0 and busy stays low.
module ex_stage_pipe #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int BR_SHIFT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic [WORD_SIZE-1:0] data2,
    input  logic [WORD_SIZE-1:0] wb_forward1,
    input  logic [WORD_SIZE-1:0] wb_forward2,
    input  logic [WORD_SIZE-1:0] mem_forward1,
    input  logic [WORD_SIZE-1:0] mem_forward2,
    input  logic [1:0]           sel_forward1,
    input  logic [1:0]           sel_forward2,
    input  logic [REG_SEL-1:0]   rd,
    input  logic [WORD_SIZE-1:0] immd,
    input  logic [3:0]           alu_op,
    input  logic                 alu_src,
    input  logic                 md_en,
    input  logic [2:0]           md_op,
    input  logic [1:0]           data_size,
    input  logic                 data_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] result,
    output logic [WORD_SIZE-1:0] save_data,
    output logic                 zero,
    output logic [ADDR_SIZE-1:0] branch_target,
    output logic [REG_SEL-1:0]   rd_out,
    output logic [1:0]           data_size_out,
    output logic                 data_sign_out,
    output logic                 busy
);

    localparam int SH_W = $clog2(WORD_SIZE);

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {IDLE, MD_BUSY, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

    state_t                 state;
    logic [WORD_SIZE-1:0]   op_a, fwd_b, op_b, alu_res, fast_res;
    logic [ADDR_SIZE-1:0]   bt_calc;
    logic                   accept;

    assign in_ready = (state == IDLE) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign op_b     = alu_src ? immd : fwd_b;
    assign bt_calc  = pc + (ADDR_SIZE'($signed(immd)) << BR_SHIFT);

    // Operand forwarding muxes; select 11 falls back to the register file.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        op_a  = data1;
        fwd_b = data2;
        case (sel_forward1)
            2'b01:   op_a = wb_forward1;
            2'b10:   op_a = mem_forward1;
            default: op_a = data1;
        endcase
        case (sel_forward2)
            2'b01:   fwd_b = wb_forward2;
            2'b10:   fwd_b = mem_forward2;
            default: fwd_b = data2;
        endcase
    end

    // Single-cycle ALU; undefined opcodes produce zero.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'b0000: alu_res = op_a + op_b;
            4'b1000: alu_res = op_a - op_b;
            4'b0001: alu_res = op_a << op_b[SH_W-1:0];
            4'b0010: alu_res = {{(WORD_SIZE-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b0011: alu_res = {{(WORD_SIZE-1){1'b0}}, op_a < op_b};
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: alu_res = op_a >> op_b[SH_W-1:0];
            4'b1101: alu_res = $signed(op_a) >>> op_b[SH_W-1:0];
            4'b0110: alu_res = op_a | op_b;
            4'b0111: alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    assign fast_res = alu_res;

    logic [WORD_SIZE-1:0]   md_acc, md_lo, md_b, md_a;
    logic [SH_W-1:0]        md_cnt;
    logic [2:0]             md_op_q;
    logic                   md_neg_q, md_neg_r, md_div0;
    logic                   a_signed, b_signed, a_neg, b_neg;
    logic [WORD_SIZE-1:0]   a_mag, b_mag, acc_nx, lo_nx, md_final;
    logic [WORD_SIZE:0]     mul_sum, div_shift, div_trial;
    logic [2*WORD_SIZE-1:0] prod, prod_s;

    assign a_signed = md_op inside {3'b001, 3'b010, 3'b100, 3'b110};
    assign b_signed = md_op inside {3'b001, 3'b100, 3'b110};
    assign a_neg    = a_signed & op_a[WORD_SIZE-1];
    assign b_neg    = b_signed & op_b[WORD_SIZE-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;

    // One iteration of shift-add multiply or restoring divide on magnitudes,
    // plus the sign/special-case fixup used on the final iteration.
    always_comb begin
        mul_sum   = {1'b0, md_acc} + (md_lo[0] ? {1'b0, md_b} : '0);
        div_shift = {md_acc, md_lo[WORD_SIZE-1]};
        div_trial = div_shift - {1'b0, md_b};
        if (md_op_q[2]) begin
            acc_nx = div_trial[WORD_SIZE] ? div_shift[WORD_SIZE-1:0] : div_trial[WORD_SIZE-1:0];
            lo_nx  = {md_lo[WORD_SIZE-2:0], ~div_trial[WORD_SIZE]};
        end else begin
            acc_nx = mul_sum[WORD_SIZE:1];
            lo_nx  = {mul_sum[0], md_lo[WORD_SIZE-1:1]};
        end
        prod   = {acc_nx, lo_nx};
        prod_s = md_neg_q ? -prod : prod;
        case (md_op_q)
            3'b000:         md_final = prod_s[WORD_SIZE-1:0];
            3'b100, 3'b101: md_final = md_div0 ? '1 : (md_neg_q ? -lo_nx : lo_nx);
            3'b110, 3'b111: md_final = md_div0 ? md_a : (md_neg_r ? -acc_nx : acc_nx);
            default:        md_final = prod_s[2*WORD_SIZE-1:WORD_SIZE];
        endcase
    end
`else
    assign fast_res = md_en ? '0 : alu_res;
    logic unused_md_op;
    assign unused_md_op = ^md_op;
`endif

    // Control FSM and registered output slot; flush kills both the in-flight
    // op and the output slot and wins over a simultaneous accept.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            result        <= '0;
            save_data     <= '0;
            zero          <= 1'b0;
            branch_target <= '0;
            rd_out        <= '0;
            data_size_out <= '0;
            data_sign_out <= 1'b0;
`ifdef EX_MULDIV_EN
            md_acc   <= '0;
            md_lo    <= '0;
            md_b     <= '0;
            md_a     <= '0;
            md_cnt   <= '0;
            md_op_q  <= '0;
            md_neg_q <= 1'b0;
            md_neg_r <= 1'b0;
            md_div0  <= 1'b0;
`endif
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        // Passthroughs load at accept; the old slot drains this same edge.
                        save_data     <= fwd_b;
                        branch_target <= bt_calc;
                        rd_out        <= rd;
                        data_size_out <= data_size;
                        data_sign_out <= data_sign;
`ifdef EX_MULDIV_EN
                        if (md_en) begin
                            state     <= MD_BUSY;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            md_acc    <= '0;
                            md_lo     <= a_mag;
                            md_b      <= b_mag;
                            md_a      <= op_a;
                            md_cnt    <= '0;
                            md_op_q   <= md_op;
                            md_neg_q  <= a_neg ^ b_neg;
                            md_neg_r  <= a_neg;
                            md_div0   <= (op_b == '0);
                        end else
`endif
                        begin
                            result    <= fast_res;
                            zero      <= (fast_res == '0);
                            out_valid <= 1'b1;
                            state     <= out_ready ? IDLE : HOLD;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
`ifdef EX_MULDIV_EN
                MD_BUSY: begin
                    md_acc <= acc_nx;
                    md_lo  <= lo_nx;
                    md_cnt <= md_cnt + 1'b1;
                    if (md_cnt == SH_W'(WORD_SIZE - 1)) begin
                        result    <= md_final;
                        zero      <= (md_final == '0);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= out_ready ? IDLE : HOLD;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: a transaction-level model predicts
// each accepted op's outputs, a scoreboard compares them every cycle the
// output slot is valid, and directed ops pin the model with literal values.
// Honours EX_MULDIV_EN the same way the design does.
module tb_ex_stage_pipe;

    localparam int W  = 32;
    localparam int A  = 32;
    localparam int RS = 5;

    logic          clk, rst_n, flush, in_valid, in_ready;
    logic [A-1:0]  pc;
    logic [W-1:0]  data1, data2, wb_forward1, wb_forward2, mem_forward1, mem_forward2, immd;
    logic [1:0]    sel_forward1, sel_forward2, data_size, data_size_out;
    logic [RS-1:0] rd, rd_out;
    logic [3:0]    alu_op;
    logic          alu_src, md_en, data_sign, data_sign_out;
    logic [2:0]    md_op;
    logic          out_valid, out_ready, zero, busy;
    logic [W-1:0]  result, save_data;
    logic [A-1:0]  branch_target;

    ex_stage_pipe #(.WORD_SIZE(W), .ADDR_SIZE(A), .NUM_REGS(32), .REG_SEL(RS), .BR_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .data1(data1), .data2(data2), .wb_forward1(wb_forward1), .wb_forward2(wb_forward2),
        .mem_forward1(mem_forward1), .mem_forward2(mem_forward2), .sel_forward1(sel_forward1),
        .sel_forward2(sel_forward2), .rd(rd), .immd(immd), .alu_op(alu_op), .alu_src(alu_src),
        .md_en(md_en), .md_op(md_op), .data_size(data_size), .data_sign(data_sign),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .save_data(save_data),
        .zero(zero), .branch_target(branch_target), .rd_out(rd_out), .data_size_out(data_size_out),
        .data_sign_out(data_sign_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  result;
        logic          zero;
        logic [W-1:0]  save;
        logic [A-1:0]  bt;
        logic [RS-1:0] rd;
        logic [1:0]    size;
        logic          sign;
    } exp_t;

    exp_t         sb[$];
    int           checks, errors, n_acc;
    logic         last_accept, stall_prev;
    logic [W-1:0] prev_result;
    logic [A-1:0] prev_bt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef EX_MULDIV_EN
    function automatic logic [W-1:0] muldiv(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] sa, ua, sbx, ubx, p;
        logic [W-1:0] mn;
        sa  = {{32{a[31]}}, a};
        ua  = {32'b0, a};
        sbx = {{32{b[31]}}, b};
        ubx = {32'b0, b};
        mn  = 32'h8000_0000;
        case (op)
            3'd0: begin p = ua * ubx; return p[31:0]; end
            3'd1: begin p = sa * sbx; return p[63:32]; end
            3'd2: begin p = sa * ubx; return p[63:32]; end
            3'd3: begin p = ua * ubx; return p[63:32]; end
            3'd4: return (b == 0) ? '1 : ((a == mn && b == '1) ? mn : W'($signed(a) / $signed(b)));
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: return (b == 0) ? a : ((a == mn && b == '1) ? '0 : W'($signed(a) % $signed(b)));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction
`endif

    // Expected outputs for the op currently presented on the inputs.
    function automatic exp_t model();
        exp_t e;
        logic [W-1:0] a, bf, b, r;
        a  = (sel_forward1 == 2'b01) ? wb_forward1 : (sel_forward1 == 2'b10) ? mem_forward1 : data1;
        bf = (sel_forward2 == 2'b01) ? wb_forward2 : (sel_forward2 == 2'b10) ? mem_forward2 : data2;
        b  = alu_src ? immd : bf;
        case (alu_op)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << b[4:0];
            4'b0010: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'b0011: r = (a < b) ? 1 : 0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $signed(a) >>> b[4:0];
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = 0;
        endcase
`ifdef EX_MULDIV_EN
        if (md_en) r = muldiv(md_op, a, b);
`else
        if (md_en) r = 0;
`endif
        e.result = r;
        e.zero   = (r == 0);
        e.save   = bf;
        e.bt     = pc + (immd * 4);
        e.rd     = rd;
        e.size   = data_size;
        e.sign   = data_sign;
        return e;
    endfunction

    // Per-cycle compare against the scoreboard, sampled mid-cycle.
    task automatic monitor();
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            stall_prev  = 1'b0;
            last_accept = 1'b0;
            return;
        end
        if (stall_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_result", result, prev_result);
            check("stall_bt", branch_target, prev_bt);
        end
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                e = sb[0];
                check("result", result, e.result);
                check("zero", zero, e.zero);
                check("save_data", save_data, e.save);
                check("branch_target", branch_target, e.bt);
                check("rd_out", rd_out, e.rd);
                check("data_size_out", data_size_out, e.size);
                check("data_sign_out", data_sign_out, e.sign);
                if (out_ready && !flush) void'(sb.pop_front());
            end
        end
        stall_prev  = out_valid & ~out_ready & ~flush;
        prev_result = result;
        prev_bt     = branch_target;
        if (flush) sb.delete();
        last_accept = in_valid & in_ready & ~flush;
        if (last_accept) begin
            sb.push_back(model());
            n_acc++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; pc = 0; data1 = 0; data2 = 0;
        wb_forward1 = 0; wb_forward2 = 0; mem_forward1 = 0; mem_forward2 = 0;
        sel_forward1 = 0; sel_forward2 = 0; rd = 0; immd = 0; alu_op = 0; alu_src = 0;
        md_en = 0; md_op = 0; data_size = 0; data_sign = 0; out_ready = 1;
    endtask

    task automatic do_send(output int n);
        in_valid = 1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (last_accept) break;
        end
        check("accept_timeout", last_accept, 1);
        in_valid = 0;
    endtask

    task automatic wait_out(input string name);
        for (int i = 0; i < 100; i++) begin
            if (out_valid) break;
            step();
        end
        check(name, out_valid, 1);
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] ops[10];
    int n;

    initial begin
        checks = 0; errors = 0; n_acc = 0; stall_prev = 0; last_accept = 0;
        prev_result = 0; prev_bt = 0;
        ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
        clear_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_bt", branch_target, 0);
        check("rst_save", save_data, 0);
        repeat (2) step();
        rst_n = 1;
        step();

        // ADD with exact one-cycle latency
        data1 = 10; data2 = 5; pc = 100; immd = 0;
        do_send(n);
        check("add_valid", out_valid, 1);
        check("add_result", result, 15);
        check("add_zero", zero, 0);
        check("add_bt", branch_target, 100);

        // Backpressure, then same-cycle accept on release
        out_ready = 0;
        repeat (3) begin
            step();
            check("bp_result", result, 15);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        clear_inputs();
        data1 = 5; data2 = 5; alu_op = 4'b1000; immd = 16; pc = 100;
        #1;
        check("release_in_ready", in_ready, 1);
        do_send(n);
        check("release_same_cycle", n, 1);
        check("sub_result", result, 0);
        check("sub_zero", zero, 1);
        check("sub_bt", branch_target, 164);

        // Forwarding
        clear_inputs();
        sel_forward1 = 2'b01; sel_forward2 = 2'b10; wb_forward1 = 123; mem_forward2 = 456;
        data1 = 7; data2 = 9;
        do_send(n);
        check("fwd_result", result, 579);
        check("fwd_save", save_data, 456);

`ifdef EX_MULDIV_EN
        clear_inputs();
        md_en = 1; md_op = 3'b000; data1 = 32'hFFFF_FFFF; data2 = 2;
        do_send(n);
        check("mul_busy", busy, 1);
        check("mul_in_ready", in_ready, 0);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check("mul_busy_cycles", n, 32);
        check("mul_valid", out_valid, 1);
        check("mul_result", result, 32'hFFFF_FFFE);
        md_op = 3'b001;
        do_send(n); wait_out("mulh_valid");
        check("mulh_result", result, 32'hFFFF_FFFF);
        md_op = 3'b100; data1 = 7; data2 = 0;
        do_send(n); wait_out("div0_valid");
        check("div0_result", result, 32'hFFFF_FFFF);
        md_op = 3'b110;
        do_send(n); wait_out("rem0_valid");
        check("rem0_result", result, 7);
        md_op = 3'b100; data1 = 32'h8000_0000; data2 = 32'hFFFF_FFFF;
        do_send(n); wait_out("ovf_valid");
        check("ovf_result", result, 32'h8000_0000);

        // Flush at cycle 10 of a divide
        data1 = 100; data2 = 3;
        do_send(n);
        repeat (9) step();
        flush = 1;
        step();
        flush = 0;
        check("flush_busy", busy, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_valid", out_valid, 0);
        repeat (40) begin
            step();
            check("flush_no_valid", out_valid, 0);
        end

        // Reset in the middle of a multiply
        md_op = 3'b011;
        do_send(n);
        repeat (5) step();
        rst_n = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", result, 0);
        step();
        rst_n = 1;
        step();
        check("midrst_valid", out_valid, 0);
`else
        clear_inputs();
        md_en = 1; md_op = 3'b000; data1 = 3; data2 = 4;
        do_send(n);
        check("md_off_valid", out_valid, 1);
        check("md_off_result", result, 0);
        check("md_off_zero", zero, 1);
        check("md_off_busy", busy, 0);
`endif

        // Randomised traffic
        clear_inputs();
        for (int c = 0; c < 1500; c++) begin
            int idx;
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = !out_valid && ($urandom_range(0, 39) == 0);
            data1 = rnd_word(); data2 = rnd_word(); immd = rnd_word(); pc = $urandom;
            wb_forward1 = rnd_word(); wb_forward2 = rnd_word();
            mem_forward1 = rnd_word(); mem_forward2 = rnd_word();
            sel_forward1 = 2'($urandom); sel_forward2 = 2'($urandom);
            rd = RS'($urandom); data_size = 2'($urandom); data_sign = 1'($urandom);
            alu_src = 1'($urandom);
            idx = $urandom_range(0, 10);
            alu_op = (idx == 10) ? 4'($urandom) : ops[idx];
            md_en = ($urandom_range(0, 7) == 0);
            md_op = 3'($urandom);
            step();
        end

        clear_inputs();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            step();
        end
        check("drain_empty", sb.size(), 0);
        check("enough_accepts", (n_acc >= 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
